// File: rtl/tis_port_unit_if.sv
// Request, status and neighbour-link signals of tis_port_unit.
// slave: the port unit itself; master: node decode/execute plus neighbour links.
interface tis_port_unit_if #(
    parameter int WORD_SIZE = 11,
    parameter int NUM_PORTS = 4,
    parameter int DIR_W     = $clog2(NUM_PORTS + 3)
);
    logic                           req_valid;
    logic                           req_write;
    logic [DIR_W-1:0]               req_dir;
    logic [WORD_SIZE-1:0]           wr_data;
    logic                           busy;
    logic                           done;
    logic [WORD_SIZE-1:0]           rd_data;
    logic [NUM_PORTS*WORD_SIZE-1:0] out_data;
    logic [NUM_PORTS-1:0]           out_valid;
    logic [NUM_PORTS-1:0]           out_ready;
    logic [NUM_PORTS*WORD_SIZE-1:0] in_data;
    logic [NUM_PORTS-1:0]           in_valid;
    logic [NUM_PORTS-1:0]           in_ready;

    modport slave (
        input  req_valid, req_write, req_dir, wr_data, out_ready, in_data, in_valid,
        output busy, done, rd_data, out_data, out_valid, in_ready
    );

    modport master (
        output req_valid, req_write, req_dir, wr_data, out_ready, in_data, in_valid,
        input  busy, done, rd_data, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/tis_port_unit.sv
// Blocking MOV-style port unit for a TIS-100 node: one read/write per request on a
// neighbour, ANY, LAST or NIL. Define TIS_ANY_RR_EN for round-robin ANY priority.
module tis_port_unit #(
    parameter int WORD_SIZE = 11,
    parameter int NUM_PORTS = 4,
    parameter int DIR_W     = $clog2(NUM_PORTS + 3)
) (
    input  logic           CLK,
    input  logic           nRST,
    tis_port_unit_if.slave bus
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t               state, state_nxt;
    logic                 op_write;
    logic                 op_any;
    logic [NUM_PORTS-1:0] mask;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rdata;
    logic [PW-1:0]        last_port;
    logic                 last_vld;

    logic [31:0]          dir_i;
    logic [NUM_PORTS-1:0] req_mask;
    logic                 req_any;
    logic                 req_nil;

    logic [31:0]          base;
    logic [NUM_PORTS-1:0] peer;
    logic [NUM_PORTS-1:0] grant;
    logic                 blocked;
    logic [NUM_PORTS-1:0] offer;
    logic [NUM_PORTS-1:0] ov;
    logic [NUM_PORTS-1:0] ir;
    logic [NUM_PORTS-1:0] xfer;
    logic                 hit;
    logic [PW-1:0]        hit_idx;
    logic [WORD_SIZE-1:0] hit_word;

    function automatic int unsigned rank(input int unsigned p, input int unsigned b);
        return (p + NUM_PORTS - b) % NUM_PORTS;
    endfunction

    // Resolve the requested direction into a port mask; empty LAST collapses to NIL.
    always_comb begin
        dir_i    = 32'(bus.req_dir);
        req_mask = '0;
        req_any  = 1'b0;
        req_nil  = 1'b0;
        if (dir_i < 32'(NUM_PORTS)) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                req_mask[p] = (dir_i == p);
        end else if (dir_i == 32'(NUM_PORTS)) begin
            req_mask = '1;
            req_any  = 1'b1;
        end else if (dir_i == 32'(NUM_PORTS + 1) && last_vld) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                req_mask[p] = (32'(last_port) == p);
        end else begin
            req_nil = 1'b1;
        end
    end

    // ANY: a port drops its offer while a higher-priority peer is ready/offering,
    // so exactly one handshake can complete.
    always_comb begin
        base = '0;
`ifdef TIS_ANY_RR_EN
        if (last_vld && 32'(last_port) != 32'(NUM_PORTS - 1))
            base = 32'(last_port) + 32'd1;
`endif
        peer    = op_write ? bus.out_ready : bus.in_valid;
        grant   = '0;
        blocked = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            blocked = 1'b0;
            for (int unsigned q = 0; q < NUM_PORTS; q++)
                if (q != p && rank(q, base) < rank(p, base) && peer[q])
                    blocked = 1'b1;
            grant[p] = mask[p] & ~(op_any & blocked);
        end
    end

    assign offer = (state == S_WAIT) ? grant : '0;
    assign ov    = op_write ? offer : '0;
    assign ir    = op_write ? '0 : offer;
    assign xfer  = (ov & bus.out_ready) | (ir & bus.in_valid);

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_word = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (xfer[p] && !hit) begin
                hit      = 1'b1;
                hit_idx  = PW'(p);
                hit_word = bus.in_data[p*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign bus.out_valid = ov;
    assign bus.in_ready  = ir;
    assign bus.out_data  = {NUM_PORTS{wdata}};
    assign bus.rd_data   = rdata;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.req_valid) state_nxt = req_nil ? S_DONE : S_WAIT;
            S_WAIT:  if (hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_write  <= 1'b0;
            op_any    <= 1'b0;
            mask      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            last_port <= '0;
            last_vld  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_write <= bus.req_write;
                        op_any   <= req_any;
                        mask     <= req_mask;
                        if (bus.req_write)
                            wdata <= bus.wr_data;
                        else if (req_nil)
                            rdata <= '0;
                    end
                end
                S_WAIT: begin
                    if (hit) begin
                        if (!op_write)
                            rdata <= hit_word;
                        if (op_any) begin
                            last_port <= hit_idx;
                            last_vld  <= 1'b1;
                        end
                    end
                end
                default: mask <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tis_port_unit.sv
// Self-checking bench for tis_port_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized requests against a behavioural model.
module tb_tis_port_unit;

    localparam int W  = 11;
    localparam int N  = 4;
    localparam int DW = 3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    tis_port_unit_if #(.WORD_SIZE(W), .NUM_PORTS(N)) bus ();

    tis_port_unit #(.WORD_SIZE(W), .NUM_PORTS(N)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        bit           wr;
        logic [DW-1:0] dir;
        logic [W-1:0] wd;
        logic [N-1:0] peer;
        bit           nil;
        logic [N-1:0] offer;
        logic [N-1:0] hs;
        logic [W-1:0] rd;
    } vec_t;

    vec_t tbl [9];

    int checks = 0;
    int errors = 0;
    int m_last = -1;
    logic [W-1:0] exp_rd;
    logic [W-1:0] words [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [DW-1:0] dir, input logic [W-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_dir   = dir;
        bus.wr_data   = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic set_peers(input bit wr, input logic [N-1:0] p, input logic [N-1:0] other);
        if (wr) begin
            bus.out_ready = p;
            bus.in_valid  = other;
        end else begin
            bus.in_valid  = p;
            bus.out_ready = other;
        end
    endtask

    task automatic load_words();
        for (int p = 0; p < N; p++)
            bus.in_data[p*W +: W] = words[p];
    endtask

    task automatic pattern_words();
        for (int p = 0; p < N; p++)
            words[p] = W'(32'h100 + p * 32'h11);
        load_words();
    endtask

    function automatic logic [N-1:0] handshakes(input bit wr);
        return wr ? (bus.out_valid & bus.out_ready) : (bus.in_ready & bus.in_valid);
    endfunction

    function automatic logic [N-1:0] offers(input bit wr);
        return wr ? bus.out_valid : bus.in_ready;
    endfunction

    // Model: ANY takes the first asserted peer walking the priority order.
    function automatic int any_winner(input logic [N-1:0] p);
        int b = 0;
`ifdef TIS_ANY_RR_EN
        if (m_last >= 0) b = (m_last + 1) % N;
`endif
        for (int k = 0; k < N; k++)
            if (p[(b + k) % N]) return (b + k) % N;
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_dir   = '0;
        bus.wr_data   = '0;
        bus.out_ready = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;

        tbl[0] = '{0, 3'd6, 11'h000, 4'b1111, 1, 4'b0000, 4'b0000, 11'h000};
        tbl[1] = '{1, 3'd5, 11'h2AA, 4'b1111, 1, 4'b0000, 4'b0000, 11'h000};
        tbl[2] = '{0, 3'd2, 11'h000, 4'b0100, 0, 4'b0100, 4'b0100, 11'h122};
        tbl[3] = '{1, 3'd4, 11'h7FF, 4'b1010, 0, 4'b0011, 4'b0010, 11'h122};
        tbl[4] = '{0, 3'd5, 11'h000, 4'b1111, 0, 4'b0010, 4'b0010, 11'h111};
        tbl[5] = '{1, 3'd0, 11'h123, 4'b0001, 0, 4'b0001, 4'b0001, 11'h111};
        tbl[6] = '{0, 3'd7, 11'h000, 4'b1111, 1, 4'b0000, 4'b0000, 11'h000};
        tbl[7] = '{1, 3'd3, 11'h456, 4'b1000, 0, 4'b1000, 4'b1000, 11'h000};
        tbl[8] = '{0, 3'd5, 11'h000, 4'b0010, 0, 4'b0010, 4'b0010, 11'h111};

        #2;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        pattern_words();
        for (int i = 0; i < 9; i++) begin
            set_peers(tbl[i].wr, tbl[i].peer, '0);
            issue(tbl[i].wr, tbl[i].dir, tbl[i].wd);
            if (tbl[i].nil) begin
                chk($sformatf("v%0d_nil_done", i), 32'(bus.done), 1);
                chk($sformatf("v%0d_nil_offers", i), 32'({bus.out_valid, bus.in_ready}), 0);
            end else begin
                chk($sformatf("v%0d_wait_done", i), 32'(bus.done), 0);
                chk($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
                chk($sformatf("v%0d_offer", i), 32'(offers(tbl[i].wr)), 32'(tbl[i].offer));
                chk($sformatf("v%0d_cross", i), 32'(offers(!tbl[i].wr)), 0);
                chk($sformatf("v%0d_hs", i), 32'(handshakes(tbl[i].wr)), 32'(tbl[i].hs));
                if (tbl[i].wr)
                    chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'({N{tbl[i].wd}}));
                tick();
                chk($sformatf("v%0d_done", i), 32'(bus.done), 1);
                chk($sformatf("v%0d_done_offers", i), 32'({bus.out_valid, bus.in_ready}), 0);
            end
            chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(tbl[i].rd));
            set_peers(tbl[i].wr, '0, '0);
            tick();
            chk($sformatf("v%0d_idle", i), 32'({bus.busy, bus.done}), 0);
        end

        // Blocking read: neighbour 2 withholds data for five cycles.
        set_peers(0, 4'b1011, '0);
        issue(0, 3'd2, '0);
        for (int c = 0; c < 5; c++) begin
            chk("blk_busy", 32'(bus.busy), 1);
            chk("blk_done", 32'(bus.done), 0);
            chk("blk_in_ready", 32'(bus.in_ready), 32'(4'b0100));
            chk("blk_hs", 32'(handshakes(0)), 0);
            tick();
        end
        words[2] = 11'h155;
        load_words();
        bus.in_valid = 4'b1111;
        #1;
        chk("blk_hs_go", 32'(handshakes(0)), 32'(4'b0100));
        tick();
        chk("blk_done_go", 32'(bus.done), 1);
        chk("blk_rd_data", 32'(bus.rd_data), 32'h155);
        bus.in_valid = '0;
        tick();
        chk("blk_idle", 32'(bus.busy), 0);

        // Reset during a pending write must drop offers and forget LAST.
        set_peers(1, 4'b0010, '0);
        issue(1, 3'd4, 11'h0AB);
        tick();
        tick();
        set_peers(1, '0, '0);
        issue(1, 3'd3, 11'h3C3);
        tick();
        chk("rw_pending", 32'(bus.out_valid), 32'(4'b1000));
        #2 nRST = 1'b0;
        #1;
        chk("rw_out_valid", 32'(bus.out_valid), 0);
        chk("rw_busy", 32'(bus.busy), 0);
        chk("rw_done", 32'(bus.done), 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        set_peers(1, 4'b1111, '0);
        issue(1, 3'd5, 11'h111);
        chk("rw_last_nil_done", 32'(bus.done), 1);
        chk("rw_last_nil_ov", 32'(bus.out_valid), 0);
        set_peers(1, '0, '0);
        tick();

        // Three ANY reads with every neighbour offering.
        begin
            int rr_exp [3];
`ifdef TIS_ANY_RR_EN
            rr_exp = '{0, 1, 2};
`else
            rr_exp = '{0, 0, 0};
`endif
            pattern_words();
            set_peers(0, 4'b1111, '0);
            for (int k = 0; k < 3; k++) begin
                issue(0, 3'd4, '0);
                chk($sformatf("rr%0d_in_ready", k), 32'(bus.in_ready), 32'(1) << rr_exp[k]);
                chk($sformatf("rr%0d_hs", k), 32'(handshakes(0)), 32'(1) << rr_exp[k]);
                tick();
                chk($sformatf("rr%0d_rd_data", k), 32'(bus.rd_data), 32'(words[rr_exp[k]]));
                tick();
            end
            set_peers(0, '0, '0);
        end

        // Randomized requests against the model, from a fresh reset.
        nRST = 1'b0;
        #3;
        nRST   = 1'b1;
        m_last = -1;
        exp_rd = '0;
        tick();
        for (int r = 0; r < 60; r++) begin
            bit            wr;
            logic [DW-1:0] dir;
            logic [W-1:0]  d;
            int            tgt;
            bit            nil;
            bit            got;
            wr  = 1'($urandom_range(0, 1));
            dir = DW'($urandom_range(0, 7));
            d   = W'($urandom);
            nil = (dir > 3'd5) || (dir == 3'd5 && m_last < 0);
            tgt = (dir == 3'd5) ? m_last : int'(dir);
            issue(wr, dir, d);
            if (nil) begin
                if (!wr) exp_rd = '0;
                chk("rnd_nil_done", 32'(bus.done), 1);
                chk("rnd_nil_offers", 32'({bus.out_valid, bus.in_ready}), 0);
                chk("rnd_nil_rd", 32'(bus.rd_data), 32'(exp_rd));
                tick();
                continue;
            end
            got = 0;
            for (int c = 0; c < 60 && !got; c++) begin
                logic [N-1:0] p;
                int win;
                p = N'($urandom & $urandom);
                for (int q = 0; q < N; q++) words[q] = W'($urandom);
                load_words();
                set_peers(wr, p, N'($urandom));
                #1;
                if (dir == 3'd4) win = any_winner(p);
                else             win = p[tgt] ? tgt : -1;
                chk("rnd_hs", 32'(handshakes(wr)), (win >= 0) ? (32'(1) << win) : 0);
                chk("rnd_wait_done", 32'(bus.done), 0);
                if (wr) chk("rnd_out_data", 32'(bus.out_data), 32'({N{d}}));
                if (win >= 0) begin
                    got = 1;
                    if (!wr) exp_rd = words[win];
                    if (dir == 3'd4) m_last = win;
                end
                tick();
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout actual=no_transfer required=transfer");
            end
            chk("rnd_done", 32'(bus.done), 1);
            chk("rnd_rd_data", 32'(bus.rd_data), 32'(exp_rd));
            set_peers(wr, '0, '0);
            tick();
            chk("rnd_idle", 32'(bus.busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tis_port_unit.md
Name: tis_port_unit

Overview:
- Parametrised blocking port unit for a TIS-100 node, generalising the fixed 4-direction, 11-bit word scheme to NUM_PORTS neighbours and WORD_SIZE bits.
- Executes one MOV-style read or write per request against UP/DOWN/LEFT/RIGHT (index), ANY, LAST or NIL, using valid/ready handshakes to neighbour nodes.
- Sits between node decode/execute and the inter-node links.
- Tracks the LAST port.

Parameters:
- WORD_SIZE, 11: data word width.
- NUM_PORTS, 4: neighbour port count (0=UP, 1=DOWN, 2=LEFT, 3=RIGHT at default).
- DIR_W, $clog2(NUM_PORTS+3): request direction width, derived; do not override.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_write  in  1  1=write wr_data out, 0=read.
- req_dir  in  DIR_W  target: 0..NUM_PORTS-1 specific, NUM_PORTS=ANY, NUM_PORTS+1=LAST, others=NIL.
- wr_data  in  WORD_SIZE  write data, captured with request.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rd_data  out  WORD_SIZE  read result, valid with done, held until next done.
- out_data  out  NUM_PORTS*WORD_SIZE  per-port write data.
- out_valid  out  NUM_PORTS  per-port write offer.
- out_ready  in  NUM_PORTS  neighbour ready; must not depend on out_valid.
- in_data  in  NUM_PORTS*WORD_SIZE  per-port read data.
- in_valid  in  NUM_PORTS  neighbour offer; must not depend on in_ready.
- in_ready  out  NUM_PORTS  per-port read acceptance.

Behaviour:
- Reset values:
  - state=IDLE; busy=0, done=0, rd_data=0.
  - out_valid=0, in_ready=0, out_data=0.
  - last_port=0, last_vld=0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On req_valid, capture write, dir and data.
  - LAST with last_vld=0 resolves to NIL.
  - NIL goes directly to DONE: read gives rd_data=0; write data is discarded.
  - Otherwise go to WAIT.
- WAIT (registered offer mask):
  - Read: in_ready asserted on target port(s).
  - Write: out_valid asserted on target port(s); out_data replicated to all ports.
  - A transfer occurs on port p in a cycle where valid[p]&ready[p].
  - On transfer: go to DONE. A read captures in_data[p] into rd_data.
  - Stays in WAIT indefinitely; there is no timeout (TIS blocking semantics).
- ANY arbitration:
  - Write: out_valid[p] is gated combinationally to 0 if any higher-priority port has out_ready=1.
  - Read: in_ready[p] is gated combinationally to 0 if any higher-priority port has in_valid=1.
  - Guarantees exactly one transfer per request.
  - Default priority: index 0 highest.
  - On an ANY transfer, last_port<=p and last_vld<=1.
  - Specific-port and LAST transfers do not update last_port.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - All offers deasserted in DONE.
  - req_valid in DONE is ignored.
- Latency:
  - Transfer in the first WAIT cycle gives done 2 cycles after the req_valid edge.
  - NIL gives done 1 cycle after the req_valid edge.
- Async reset mid-WAIT: offers drop immediately and the pending transfer is lost; last_vld clears.

Optional Feature:
- Macro TIS_ANY_RR_EN.
  - Defined: ANY priority is round-robin. The highest-priority port is (last_port+1) mod NUM_PORTS; 0 when last_vld=0.
  - Undefined: fixed priority, index 0 highest.
- Non-ANY behaviour is identical in both builds.

Test Plan:
- NIL and empty LAST:
  - Read NIL (dir=6): done at +1, rd_data=0, no in_ready ever.
  - Write LAST after reset: done at +1, out_valid never high.
- Blocking read:
  - Read dir=2; hold in_valid[2]=0 for 5 cycles; then in_valid[2]=1, in_data[2]=0x155.
  - Expect busy throughout, done the cycle after the handshake, rd_data=0x155.
- ANY write contention:
  - Write 0x7FF to ANY; out_ready=4'b1010 in the same cycle.
  - Expect a transfer only on port 1; out_valid[3]=0; last_port=1.
  - A subsequent LAST read drives in_ready=4'b0010 only.
- Round-robin (TIS_ANY_RR_EN):
  - Three ANY reads with in_valid=4'b1111 constantly.
  - Expect grants on ports 0,1,2.
  - Without the macro, expect grants 0,0,0.
- Reset mid-WAIT:
  - Assert nRST=0 during a pending write to port 3.
  - Expect out_valid=0 asynchronously, busy=0, last_vld=0.
  - First request after release behaves as from reset.
